// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU memory interface. After reset a boot-load
// FSM streams the program image into the word array over a valid/ready port;
// once the final beat (or the last array word) is accepted it raises `run` and
// serves the CPU through two pipelined read ports and one write port.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   raddr0 / rdata0     instruction-fetch read port
//   raddr1 / rdata1     data-load read port
//   wen, waddr, wdata   store port (RUN only, write-first on collisions)
//   load_valid/ready    boot-load handshake; load_data is the beat word,
//   load_data/last      load_last marks the final beat of the image
//   run                 high once loading has completed (terminal until reset)
//   load_count          number of words written by the loader (saturating)
//
// Read latency: address sampled at edge N, data visible after edge
// N+RD_LAT-1. Stage 1 is the array output register; stages 2..RD_LAT are a
// resettable delay line. Legal RD_LAT values are 1..4.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              run,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  // ---------------------------------------------------------------------------
  // Boot-load FSM
  // ---------------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              vld_q;
  logic              load_fire;
  logic              run_w;
  logic              cpu_we;

  assign run_w     = (state_q == ST_RUN);
  // ready_q is only ever set while in LOAD, so it alone qualifies a beat.
  assign load_fire = ready_q & load_valid;
  // Only a clean 1 on wen writes; X/Z is treated as no write.
  assign cpu_we    = run_w & (wen === 1'b1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (load_fire) begin
      // The pointer parks on the last word instead of wrapping.
      if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (load_last || (ptr_q == PTR_MAX)) state_d = ST_RUN;
    end
    // Registered so that ready stays low until the first edge after reset
    // release and drops on the same edge that run rises.
    ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      // Marks that the array output register holds a RUN-time read.
      vld_q   <= run_w;
    end
  end

  assign run        = run_w;
  assign load_ready = ready_q;
  assign load_count = cnt_q;

  // ---------------------------------------------------------------------------
  // Word array: one shared write port (loader in LOAD, CPU store in RUN)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign mem_we = load_fire | cpu_we;
  assign mem_wa = run_w ? waddr : ptr_q;
  assign mem_wd = run_w ? wdata : load_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [1:0][ADDR_W-1:0] raddr_pk;
  logic [1:0][DATA_W-1:0] rdata_pk;

  assign raddr_pk = {raddr1, raddr0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] raw_q;
      logic [DATA_W-1:0] s1;

      // Array output register, left without reset so it maps onto RAM.
      // A same-edge store to the read address is forwarded (write-first).
      always_ff @(posedge clk) begin
        raw_q <= (cpu_we && (waddr == raddr_pk[gi])) ? wdata : mem[raddr_pk[gi]];
      end

      // Gating with vld_q gives zero during LOAD and an immediate zero on
      // reset, so nothing sampled before reset can ever be delivered.
      assign s1 = vld_q ? raw_q : '0;

      if (RD_LAT == 1) begin : g_lat1
        assign rdata_pk[gi] = s1;
      end else begin : g_pipe
        logic [DATA_W-1:0] pipe_q [0:RD_LAT-2];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < RD_LAT - 1; i++) pipe_q[i] <= '0;
          end else begin
            pipe_q[0] <= s1;
            for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
          end
        end

        assign rdata_pk[gi] = pipe_q[RD_LAT-2];
      end
    end
  endgenerate

  assign rdata0 = rdata_pk[0];
  assign rdata1 = rdata_pk[1];

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Two responders (RD_LAT=1 and RD_LAT=3) share all inputs. Every CPU read
// pushes its expected word (from a reference memory model with write-first
// forwarding) into a per-stream queue tagged with the cycle it is due; a
// monitor on the falling edge pops and compares. Loader/FSM behaviour is
// checked directly after the relevant edges.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr0, raddr1, waddr;
  logic [DW-1:0] wdata, load_data;
  logic          wen, load_valid, load_last;

  logic [DW-1:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic          load_ready_a, load_ready_b, run_a, run_b;
  logic [AW:0]   load_count_a, load_count_b;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .rdata0(rdata0_a), .raddr1(raddr1), .rdata1(rdata1_a),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .load_valid(load_valid), .load_ready(load_ready_a),
    .load_data(load_data), .load_last(load_last),
    .run(run_a), .load_count(load_count_a)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .rdata0(rdata0_b), .raddr1(raddr1), .rdata1(rdata1_b),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .load_valid(load_valid), .load_ready(load_ready_b),
    .load_data(load_data), .load_last(load_last),
    .run(run_b), .load_count(load_count_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-28s obs=%h", tag, obs);
    end else begin
      $display("FAIL %-28s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] exp;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];

  logic [DW-1:0] model [0:(1<<AW)-1];

  // Scoreboard monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (qa0.size() > 0 && qa0[0].due <= cyc) begin
      e = qa0.pop_front();
      check_eq($sformatf("lat1.rdata0[%h]", e.addr), 32'(rdata0_a), 32'(e.exp));
    end
    while (qa1.size() > 0 && qa1[0].due <= cyc) begin
      e = qa1.pop_front();
      check_eq($sformatf("lat1.rdata1[%h]", e.addr), 32'(rdata1_a), 32'(e.exp));
    end
    while (qb0.size() > 0 && qb0[0].due <= cyc) begin
      e = qb0.pop_front();
      check_eq($sformatf("lat3.rdata0[%h]", e.addr), 32'(rdata0_b), 32'(e.exp));
    end
    while (qb1.size() > 0 && qb1[0].due <= cyc) begin
      e = qb1.pop_front();
      check_eq($sformatf("lat3.rdata1[%h]", e.addr), 32'(rdata1_b), 32'(e.exp));
    end
  end

  // Called 1 time unit after a rising edge; drives one RUN-state CPU cycle.
  task automatic cpu_cycle(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t e;
    raddr0 = r0;
    raddr1 = r1;
    wen    = we;
    waddr  = wa;
    wdata  = wd;
    e.addr = r0;
    e.exp  = (we && wa == r0) ? wd : model[r0];
    e.due  = cyc + 1; qa0.push_back(e);
    e.due  = cyc + 3; qb0.push_back(e);
    e.addr = r1;
    e.exp  = (we && wa == r1) ? wd : model[r1];
    e.due  = cyc + 1; qa1.push_back(e);
    e.due  = cyc + 3; qb1.push_back(e);
    if (we) model[wa] = wd;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic load_beat(input logic [DW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
  endtask

  function automatic logic [DW-1:0] fill_word(input int i);
    return 16'(i) ^ 16'h5A3C;
  endfunction

  logic [AW-1:0] addr_set [0:4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_set[0] = 15'h0000; addr_set[1] = 15'h0001; addr_set[2] = 15'h0002;
    addr_set[3] = 15'h0010; addr_set[4] = 15'h0011;
    rst_n = 1'b0;
    raddr0 = '0; raddr1 = '0; wen = 1'b0; waddr = '0; wdata = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    // ---- reset state ----
    idle(3);
    check_eq("rst.run",        32'(run_a),        32'd0);
    check_eq("rst.load_ready", 32'(load_ready_a), 32'd0);
    check_eq("rst.load_count", 32'(load_count_a), 32'd0);
    check_eq("rst.rdata0",     32'(rdata0_a),     32'd0);
    check_eq("rst.lat3.rdata1",32'(rdata1_b),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("ready_before_edge", 32'(load_ready_a), 32'd0);
    @(posedge clk); #1;
    check_eq("ready_after_edge",      32'(load_ready_a), 32'd1);
    check_eq("lat3.ready_after_edge", 32'(load_ready_b), 32'd1);

    // ---- load 3 beats with gaps; CPU store during LOAD must be ignored ----
    load_beat(16'h8011, 1'b0); model[0] = 16'h8011;
    load_data = 16'hDEAD;
    raddr0 = 15'h0000;
    wen = 1'b1; waddr = 15'h0000; wdata = 16'h1111;
    idle(2);
    wen = 1'b0;
    check_eq("gap.load_count", 32'(load_count_a), 32'd1);
    check_eq("gap.run",        32'(run_a),        32'd0);
    check_eq("gap.load_ready", 32'(load_ready_a), 32'd1);
    check_eq("load.rdata0_held0", 32'(rdata0_a),  32'd0);
    load_beat(16'h9001, 1'b0); model[1] = 16'h9001;
    check_eq("beat2.run", 32'(run_a), 32'd0);
    load_beat(16'hF000, 1'b1); model[2] = 16'hF000;
    check_eq("last.run",        32'(run_a),        32'd1);
    check_eq("last.lat3.run",   32'(run_b),        32'd1);
    check_eq("last.load_count", 32'(load_count_a), 32'd3);
    check_eq("last.load_ready", 32'(load_ready_a), 32'd0);

    // ---- RUN reads from the very first RUN edge, back-to-back ----
    cpu_cycle(15'h0000, 15'h0002, 1'b0, '0, '0);
    cpu_cycle(15'h0001, 15'h0001, 1'b0, '0, '0);
    cpu_cycle(15'h0002, 15'h0000, 1'b0, '0, '0);

    // Load beats in RUN are ignored.
    load_valid = 1'b1; load_last = 1'b1; load_data = 16'h7777;

    // ---- write-first collisions; in-flight reads not updated ----
    cpu_cycle(15'h0000, 15'h0010, 1'b1, 15'h0010, 16'hBEEF);
    cpu_cycle(15'h0001, 15'h0010, 1'b1, 15'h0010, 16'h1234);
    cpu_cycle(15'h0011, 15'h0010, 1'b1, 15'h0011, 16'hCAFE);
    load_valid = 1'b0; load_last = 1'b0;
    check_eq("run.load_count_frozen", 32'(load_count_a), 32'd3);
    check_eq("run.load_ready_low",    32'(load_ready_a), 32'd0);

    // ---- random mixed traffic over initialised addresses ----
    for (int i = 0; i < 16; i++) begin
      cpu_cycle(addr_set[$urandom_range(0, 4)], addr_set[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), addr_set[$urandom_range(0, 4)], 16'($urandom));
    end
    idle(4);

    // ---- asynchronous reset mid-run ----
    cpu_cycle(15'h0000, 15'h0002, 1'b0, '0, '0);
    cpu_cycle(15'h0001, 15'h0001, 1'b0, '0, '0);
    clear_queues();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.rdata0",      32'(rdata0_a),     32'd0);
    check_eq("arst.rdata1",      32'(rdata1_a),     32'd0);
    check_eq("arst.lat3.rdata0", 32'(rdata0_b),     32'd0);
    check_eq("arst.run",         32'(run_a),        32'd0);
    check_eq("arst.lat3.run",    32'(run_b),        32'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel.load_ready",   32'(load_ready_a), 32'd1);
    check_eq("rel.load_count",   32'(load_count_a), 32'd0);
    check_eq("rel.lat3.rdata0",  32'(rdata0_b),     32'd0);
    idle(1);
    check_eq("rel.lat3.rdata1",  32'(rdata1_b),     32'd0);
    load_beat(16'h5555, 1'b1); model[0] = 16'h5555;
    check_eq("reload.run",        32'(run_a),        32'd1);
    check_eq("reload.load_count", 32'(load_count_a), 32'd1);
    cpu_cycle(15'h0001, 15'h0002, 1'b0, '0, '0);
    cpu_cycle(15'h0010, 15'h0000, 1'b0, '0, '0);
    cpu_cycle(15'h0011, 15'h0011, 1'b0, '0, '0);
    idle(4);

    // ---- full-array fill without load_last ----
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_last  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      load_data = fill_word(i);
      model[i]  = fill_word(i);
      @(posedge clk); #1;
      if (i == (1 << AW) - 2) begin
        check_eq("fill.penult.load_count", 32'(load_count_a), 32'((1 << AW) - 1));
        check_eq("fill.penult.run",        32'(run_a),        32'd0);
      end
    end
    $display("fill: %0d words streamed", 1 << AW);
    check_eq("fill.run",             32'(run_a),        32'd1);
    check_eq("fill.lat3.run",        32'(run_b),        32'd1);
    check_eq("fill.load_count",      32'(load_count_a), 32'(1 << AW));
    check_eq("fill.lat3.load_count", 32'(load_count_b), 32'(1 << AW));
    check_eq("fill.load_ready",      32'(load_ready_a), 32'd0);
    load_data = 16'hAAAA;
    load_last = 1'b1;
    idle(2);
    load_valid = 1'b0;
    load_last  = 1'b0;
    check_eq("fill.extra_ignored", 32'(load_count_a), 32'(1 << AW));
    cpu_cycle(15'h7FFF, 15'h0000, 1'b0, '0, '0);
    cpu_cycle(15'h7FFE, 15'h7FFF, 1'b0, '0, '0);
    cpu_cycle(15'h4000, 15'h0001, 1'b0, '0, '0);
    idle(5);

    check_eq("scoreboard_drained", 32'(qa0.size() + qa1.size() + qb0.size() + qb1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory interface: two read ports (instruction fetch, data load) and one write port (store).
- All addresses are 15-bit word addresses.
- After reset, a boot-load FSM streams the program image into the array over a valid/ready port, then asserts `run` and begins serving the CPU.
- Sits between the memory array and the CPU pipeline; replaces the untimed behavioural memory with defined latency and reset semantics.

Parameters:
- ADDR_W, 15, word-address width; array depth is 2**ADDR_W words.
- DATA_W, 16, word width.
- RD_LAT, 1, read latency in cycles; legal values 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr0  in  ADDR_W  fetch read address (pc[15:1]).
- rdata0  out  DATA_W  fetch read data.
- raddr1  in  ADDR_W  load read address.
- rdata1  out  DATA_W  load read data.
- wen  in  1  store enable.
- waddr  in  ADDR_W  store address.
- wdata  in  DATA_W  store data.
- load_valid  in  1  boot-load beat valid.
- load_ready  out  1  boot-load beat accepted when load_valid & load_ready.
- load_data  in  DATA_W  boot-load word.
- load_last  in  1  final beat of the image.
- run  out  1  high once loading is complete; the CPU must hold halt/stall until run=1.
- load_count  out  ADDR_W+1  number of words written by the loader.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - State goes to LOAD; load pointer, load_count and run are 0; load_ready is 0.
  - rdata0 and rdata1 and all read-pipeline registers are 0.
  - Array contents are not cleared.
  - load_ready rises on the first clk edge after rst_n deasserts.
  - Reset asserted mid-load or mid-run aborts immediately; in-flight reads are discarded, never delivered.
- **State LOAD:**
  - load_ready is 1.
  - Each accepted beat writes load_data at the pointer, then increments the pointer and load_count.
  - An accepted beat with load_last=1 moves the FSM to RUN on the same edge (load_count includes that beat).
  - If the pointer reaches 2**ADDR_W-1 and that beat is accepted, the FSM enters RUN even without load_last; the pointer does not wrap.
  - CPU ports are ignored: wen has no effect and rdata0/rdata1 are held at 0.
  - load_valid=0 is a stall and changes no state.
- **State RUN:**
  - load_ready is 0 and run is 1; load beats are ignored.
  - RUN is terminal until reset.
- **Reads in RUN:**
  - The address is sampled at edge N; data appears on rdata0/rdata1 after edge N+RD_LAT-1, i.e. one cycle after the address with RD_LAT=1.
  - Both ports are fully pipelined: a new address every cycle, and the same address on both ports is legal.
- **Write:**
  - Occurs at the edge where wen===1 in RUN.
  - wen of X or Z is treated as no write.
- **Read/write collision:**
  - A read sampled at the same edge as a write to the same address returns wdata (write-first). This applies to both ports.
  - Reads already in the pipeline are not updated by later writes.
- **Load-to-run transition:**
  - The first edge in RUN samples CPU addresses normally.
  - Data from the last load beat is readable at that address from the first RUN read onward.
- **Width:** load_count saturates at 2**ADDR_W.

Test Plan:
- Reset, load 3 beats 0x8011, 0x9001, 0xF000 with load_last on the third → load_count=3, run rises on the third acceptance edge, mem[0..2] hold those values; rdata0 for raddr0=0 is 0x8011 one cycle later.
- Gaps in load_valid (1,0,0,1,1+last) → only 3 words written, load_count=3, no state change during gaps.
- RUN, RD_LAT=1: wen=1, waddr=0x0010, wdata=0xBEEF, and raddr1=0x0010 in the same cycle → rdata1=0xBEEF next cycle; a second write of 0x1234 to 0x0010 the following cycle does not alter that delivered word.
- RD_LAT=3: back-to-back raddr0 = 0, 1, 2 → rdata0 shows mem[0], mem[1], mem[2] on consecutive cycles, with the first appearing 3 cycles after its address.
- Assert rst_n low asynchronously mid-run between edges → rdata0/rdata1=0 and run=0 immediately; after release load_ready=1 and previously loaded memory is unchanged.
- Loader fills all 2**ADDR_W words without load_last → run=1 after the last word, load_count=32768, and further load beats are ignored.
